// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl -- instruction-fetch sequencer in front of DecEx.
//
// Generates the fetch PC and drives a synchronous instruction memory whose
// read data is valid the cycle after the request. Returned words go into a
// 2-entry skid FIFO. The FIFO head is presented to decode with a
// valid/stall handshake. Branch/jump redirects from execute flush the FIFO
// and kill the outstanding fetch.
//
// Handshake: an entry is transferred to decode in every cycle where
// if_valid=1 and stall=0 (a "pop"). While stall=1, every output to decode
// holds its value. The source never withdraws a valid entry except on
// redirect or reset.
//
// Parameters:
//   XLEN      PC / instruction width
//   IMEM_AW   instruction memory word-address width
//   RESET_PC  first fetch byte address (low 2 bits zero)
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-low reset
//   imem_req       read request this cycle
//   imem_adr       word address = fetch_pc[IMEM_AW+1:2]
//   imem_rdata     read data, valid the cycle after imem_req
//   stall          decode cannot accept; holds the output entry
//   redirect_valid taken branch/jump from execute
//   redirect_pc    new fetch byte address; bits [1:0] treated as 0
//   halt           stop issuing new fetches
//   if_valid       output entry valid
//   instruction    FIFO head instruction
//   pc_if          FIFO head PC (byte address)
//   pc_plus_4_if   pc_if + 4, wrapping mod 2^XLEN
//   dbg_state      FSM state: 0=BOOT, 1=RUN, 2=HALT
//
// Optional feature, enabled by defining the macro FETCH_PERF_EN:
//   perf_fetched       count of accepted pops (wraps at 2^32)
//   perf_stall_cycles  count of cycles with if_valid && stall (wraps)
// Both counters reset to 0 and survive redirects. Without the macro
// these ports do not exist. Fetch behaviour is the same in both builds.
// ---------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     IMEM_AW  = 5,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_adr,
  input  logic [XLEN-1:0]    imem_rdata,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               halt,
  output logic               if_valid,
  output logic [XLEN-1:0]    instruction,
  output logic [XLEN-1:0]    pc_if,
  output logic [XLEN-1:0]    pc_plus_4_if,
  output logic [1:0]         dbg_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  // FSM and fetch bookkeeping
  state_t            r_state;
  state_t            w_state_nxt;
  logic [XLEN-1:0]   r_fetch_pc;
  logic              r_inflight;
  logic [XLEN-1:0]   r_inflight_pc;

  // Skid FIFO: slot 0 is always the head, slot 1 the second entry.
  logic [XLEN-1:0]   r_pc0;
  logic [XLEN-1:0]   r_ins0;
  logic [XLEN-1:0]   r_pc1;
  logic [XLEN-1:0]   r_ins1;
  logic [1:0]        r_count;

  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [1:0]        w_occ;
  logic [XLEN-1:0]   w_redirect_aligned;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  assign if_valid           = (r_count != 2'd0);
  assign w_pop              = if_valid && !stall;
  // Occupancy counts the outstanding request, so a full FIFO (count=2)
  // always has nothing in flight and the sum never exceeds 2.
  assign w_occ              = r_count + {1'b0, r_inflight};
  // A response that lands in a redirect cycle belongs to the wrong path.
  assign w_push             = r_inflight && !redirect_valid;
  assign w_redirect_aligned = redirect_pc & ALIGN_MASK;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and issue decision
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_BOOT: begin
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // Redirect wins over halt: the state stays RUN and nothing issues.
        if (!redirect_valid) begin
          // Issue while a slot is free, or when the only slot that would
          // free up is being popped this very cycle.
          if ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop)) begin
            w_issue = 1'b1;
          end
          if (halt) begin
            w_state_nxt = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        if (redirect_valid) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  assign imem_req  = w_issue;
  assign imem_adr  = r_fetch_pc[IMEM_AW+1:2];
  assign dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // Fetch PC and outstanding request
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc    <= w_redirect_aligned;
      r_inflight    <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + PC_STEP;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Skid FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc0   <= '0;
      r_ins0  <= '0;
      r_pc1   <= '0;
      r_ins1  <= '0;
      r_count <= 2'd0;
    end else if (redirect_valid) begin
      // Flush: entries are discarded, a pop in this cycle is ignored.
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_pc0  <= r_inflight_pc;
            r_ins0 <= imem_rdata;
          end else begin
            r_pc1  <= r_inflight_pc;
            r_ins1 <= imem_rdata;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_pc0   <= r_pc1;
          r_ins0  <= r_ins1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_pc0  <= r_pc1;
            r_ins0 <= r_ins1;
            r_pc1  <= r_inflight_pc;
            r_ins1 <= imem_rdata;
          end else begin
            r_pc0  <= r_inflight_pc;
            r_ins0 <= imem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign instruction  = r_ins0;
  assign pc_if        = r_pc0;
  assign pc_plus_4_if = r_pc0 + PC_STEP;

`ifdef FETCH_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (not cleared by redirect)
  // ---------------------------------------------------------------------------
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall_cycles;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetched      <= 32'd0;
      r_perf_stall_cycles <= 32'd0;
    end else begin
      // A pop in a redirect cycle is discarded, so it is not counted.
      if (w_pop && !redirect_valid) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (if_valid && stall) begin
        r_perf_stall_cycles <= r_perf_stall_cycles + 32'd1;
      end
    end
  end

  assign perf_fetched      = r_perf_fetched;
  assign perf_stall_cycles = r_perf_stall_cycles;
`endif

endmodule
